// File: rtl/dm_pkg.sv
// Shared encodings, FSM state type and lane-enable helper for the data-memory access unit.
package dm_pkg;

    localparam logic [1:0] SIZ_B   = 2'b00;
    localparam logic [1:0] SIZ_H   = 2'b01;
    localparam logic [1:0] SIZ_W   = 2'b10;
    localparam logic [1:0] SIZ_RSV = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } dm_state_t;

    // Reserved size falls through to word; illegal accesses are gated by the caller.
    function automatic logic [3:0] lane_mask(input logic [1:0] siz, input logic [1:0] addr_lo);
        logic [3:0] m;
        case (siz)
            SIZ_B:   m = 4'b0001 << addr_lo;
            SIZ_H:   m = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Combinational byte-lane logic: store replication, lane mask, load extract/extend.
// Alignment legality is reported only when DM_ALIGN_CHECK_EN is defined.
module dm_lane_unit
    import dm_pkg::*;
(
    input  logic [1:0]  siz,
    input  logic [1:0]  addr_lo,
    input  logic        se,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] wdata_rep,
    output logic [3:0]  lane_en,
    output logic [31:0] rdata_ext,
    output logic        illegal
);

    logic [31:0] sh_b;
    logic [31:0] sh_h;

    assign sh_b    = rword >> {addr_lo, 3'b000};
    assign sh_h    = rword >> {addr_lo[1], 4'b0000};
    assign lane_en = lane_mask(siz, addr_lo);

    always_comb begin
        wdata_rep = wdata;
        rdata_ext = rword;
        case (siz)
            SIZ_B: begin
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{se & sh_b[7]}}, sh_b[7:0]};
            end
            SIZ_H: begin
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{se & sh_h[15]}}, sh_h[15:0]};
            end
            default: begin
                wdata_rep = wdata;
                rdata_ext = rword;
            end
        endcase
    end

`ifdef DM_ALIGN_CHECK_EN
    assign illegal = (siz == SIZ_RSV) ||
                     (siz == SIZ_H && addr_lo[0]) ||
                     (siz == SIZ_W && addr_lo != 2'b00);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: rtl/dm_access_unit.sv
// Data-memory access unit: request latch, FSM, word RAM and read pipeline.
// Optional alignment checking is enabled with DM_ALIGN_CHECK_EN.
module dm_access_unit
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk_DM,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_siz,
    input  logic              req_se,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned DEPTH = 2 ** (ADDR_W - 2);

    dm_state_t         state, state_nx;
    logic              we_q, se_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        siz_q;
    logic [31:0]       wdata_q;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       rd1, rd2, rword;
    logic [31:0]       wdata_rep, rdata_ext;
    logic [3:0]        lane_en;
    logic              illegal;
    logic [ADDR_W-3:0] waddr;

    assign waddr = addr_q[ADDR_W-1:2];
    assign rword = (RD_LAT == 2) ? rd2 : rd1;

    dm_lane_unit u_lane (
        .siz       (siz_q),
        .addr_lo   (addr_q[1:0]),
        .se        (se_q),
        .wdata     (wdata_q),
        .rword     (rword),
        .wdata_rep (wdata_rep),
        .lane_en   (lane_en),
        .rdata_ext (rdata_ext),
        .illegal   (illegal)
    );

    assign req_ready = (state == IDLE) || (state == RESP && rsp_ready);
    assign rsp_valid = (state == RESP);
    assign rsp_err   = (state == RESP) && illegal;
    // Response data is derived from latched fields and the held read word, so it stays stable in RESP.
    assign rsp_rdata = (state == RESP && !we_q && !illegal) ? rdata_ext : '0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = ACCESS;
            ACCESS:  state_nx = (RD_LAT == 2) ? WAIT : RESP;
            WAIT:    state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = req_valid ? ACCESS : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_DM or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            se_q    <= 1'b0;
            addr_q  <= '0;
            siz_q   <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nx;
            if (req_valid && req_ready) begin
                we_q    <= req_we;
                se_q    <= req_se;
                addr_q  <= req_addr;
                siz_q   <= req_siz;
                wdata_q <= req_wdata;
            end
        end
    end

    always_ff @(posedge clk_DM) begin
        if (state == ACCESS) begin
            if (we_q && !illegal) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (lane_en[i]) mem[waddr][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
            rd1 <= mem[waddr];
        end
        if (state == WAIT) rd2 <= rd1;
    end

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit; runs RD_LAT=1 and RD_LAT=2 instances side by side.
module tb_dm_access_unit;

    logic        clk_DM = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, req_se, rsp_ready;
    logic [7:0]  req_addr;
    logic [1:0]  req_siz;
    logic [31:0] req_wdata;

    logic        req_ready1, rsp_valid1, rsp_err1;
    logic        req_ready2, rsp_valid2, rsp_err2;
    logic [31:0] rsp_rdata1, rsp_rdata2;

    int checks = 0;
    int errors = 0;

    always #5 clk_DM = ~clk_DM;

    dm_access_unit #(.ADDR_W(8), .RD_LAT(1)) dut1 (
        .clk_DM(clk_DM), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready1),
        .req_we(req_we), .req_addr(req_addr), .req_siz(req_siz), .req_se(req_se),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    dm_access_unit #(.ADDR_W(8), .RD_LAT(2)) dut2 (
        .clk_DM(clk_DM), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
        .req_we(req_we), .req_addr(req_addr), .req_siz(req_siz), .req_se(req_se),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2)
    );

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [1:0]  siz;
        logic        se;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_txn(input logic we, input logic [7:0] addr, input logic [1:0] siz,
                          input logic se, input logic [31:0] wd,
                          output logic [31:0] d1, output logic e1, output int l1,
                          output logic [31:0] d2, output logic e2, output int l2);
        bit g1, g2;
        g1 = 0; g2 = 0;
        d1 = '0; d2 = '0; e1 = 1'b0; e2 = 1'b0; l1 = 0; l2 = 0;
        @(negedge clk_DM);
        req_we = we; req_addr = addr; req_siz = siz; req_se = se; req_wdata = wd;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk_DM); #1;
            req_valid = 1'b0;
            if (!g1 && rsp_valid1) begin g1 = 1; d1 = rsp_rdata1; e1 = rsp_err1; l1 = k; end
            if (!g2 && rsp_valid2) begin g2 = 1; d2 = rsp_rdata2; e2 = rsp_err2; l2 = k; end
            if (g1 && g2) break;
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        logic [31:0] d1, d2;
        logic        e1, e2;
        int          l1, l2;
        do_txn(v.we, v.addr, v.siz, v.se, v.wdata, d1, e1, l1, d2, e2, l2);
        check({tag, ".rdata_lat1"}, d1, v.exp_rdata);
        check({tag, ".rdata_lat2"}, d2, v.exp_rdata);
        check({tag, ".err_lat1"}, 32'(e1), 32'(v.exp_err));
        check({tag, ".err_lat2"}, 32'(e2), 32'(v.exp_err));
        check({tag, ".latency1"}, 32'(l1), 32'd2);
        check({tag, ".latency2"}, 32'(l2), 32'd3);
    endtask

    initial begin
        int c1, c2;
        logic [31:0] exp_align_ld, exp_h_odd, exp_rsv;
        logic        exp_align_err;

`ifdef DM_ALIGN_CHECK_EN
        exp_align_err = 1'b1;
        exp_align_ld  = 32'h01020304;
        exp_h_odd     = 32'h0;
        exp_rsv       = 32'h0;
`else
        exp_align_err = 1'b0;
        exp_align_ld  = 32'h99999999;
        exp_h_odd     = 32'h00008001;
        exp_rsv       = 32'h8001A544;
`endif

        vecs.push_back('{1'b1, 8'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 8'h13, 2'b00, 1'b1, 32'h0,        32'hFFFFFFDE, 1'b0});
        vecs.push_back('{1'b0, 8'h11, 2'b00, 1'b0, 32'h0,        32'h000000BE, 1'b0});
        vecs.push_back('{1'b0, 8'h10, 2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 8'h20, 2'b10, 1'b0, 32'h11223344, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 8'h22, 2'b01, 1'b0, 32'h00008001, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 8'h20, 2'b10, 1'b0, 32'h0,        32'h80013344, 1'b0});
        vecs.push_back('{1'b0, 8'h22, 2'b01, 1'b1, 32'h0,        32'hFFFF8001, 1'b0});
        vecs.push_back('{1'b0, 8'h22, 2'b01, 1'b0, 32'h0,        32'h00008001, 1'b0});
        vecs.push_back('{1'b0, 8'h20, 2'b10, 1'b1, 32'h0,        32'h80013344, 1'b0});
        vecs.push_back('{1'b1, 8'h21, 2'b00, 1'b0, 32'h123456A5, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 8'h20, 2'b10, 1'b0, 32'h0,        32'h8001A544, 1'b0});
        vecs.push_back('{1'b0, 8'h21, 2'b00, 1'b1, 32'h0,        32'hFFFFFFA5, 1'b0});
        vecs.push_back('{1'b0, 8'h20, 2'b01, 1'b0, 32'h0,        32'h0000A544, 1'b0});
        vecs.push_back('{1'b1, 8'hFC, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 8'hFF, 2'b00, 1'b0, 32'h0,        32'h000000CA, 1'b0});
        vecs.push_back('{1'b1, 8'h04, 2'b10, 1'b0, 32'h01020304, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 8'h05, 2'b10, 1'b0, 32'h99999999, 32'h0,        exp_align_err});
        vecs.push_back('{1'b0, 8'h04, 2'b10, 1'b0, 32'h0,        exp_align_ld, 1'b0});
        vecs.push_back('{1'b0, 8'h23, 2'b01, 1'b0, 32'h0,        exp_h_odd,    exp_align_err});
        vecs.push_back('{1'b0, 8'h20, 2'b11, 1'b0, 32'h0,        exp_rsv,      exp_align_err});

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_se = 1'b0;
        req_addr = '0; req_siz = '0; req_wdata = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk_DM);
        #1;
        check("reset.req_ready1", 32'(req_ready1), 32'd1);
        check("reset.req_ready2", 32'(req_ready2), 32'd1);
        check("reset.rsp_valid1", 32'(rsp_valid1), 32'd0);
        check("reset.rsp_valid2", 32'(rsp_valid2), 32'd0);
        check("reset.rsp_rdata1", rsp_rdata1, 32'd0);
        check("reset.rsp_err1", 32'(rsp_err1), 32'd0);
        @(negedge clk_DM);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec($sformatf("v%0d", i), vecs[i]);

        // Back-to-back throughput with rsp_ready held high
        repeat (2) @(negedge clk_DM);
        req_we = 1'b0; req_addr = 8'h10; req_siz = 2'b10; req_se = 1'b0;
        req_valid = 1'b1; rsp_ready = 1'b1;
        c1 = 0; c2 = 0;
        for (int i = 0; i < 12; i++) begin
            if (req_ready1) c1++;
            if (req_ready2) c2++;
            @(negedge clk_DM);
        end
        req_valid = 1'b0;
        check("thru.accepts_lat1", 32'(c1), 32'd6);
        check("thru.accepts_lat2", 32'(c2), 32'd4);
        repeat (4) @(negedge clk_DM);

        // Backpressure: held response, competing store must not be accepted
        req_we = 1'b0; req_addr = 8'h10; req_siz = 2'b10; req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk_DM); #1;
        req_we = 1'b1; req_wdata = 32'h55555555;
        repeat (2) @(posedge clk_DM);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_DM); #1;
            check($sformatf("bp%0d.rsp_valid1", i), 32'(rsp_valid1), 32'd1);
            check($sformatf("bp%0d.rsp_valid2", i), 32'(rsp_valid2), 32'd1);
            check($sformatf("bp%0d.rdata1", i), rsp_rdata1, 32'hDEADBEEF);
            check($sformatf("bp%0d.rdata2", i), rsp_rdata2, 32'hDEADBEEF);
            check($sformatf("bp%0d.req_ready1", i), 32'(req_ready1), 32'd0);
            check($sformatf("bp%0d.req_ready2", i), 32'(req_ready2), 32'd0);
        end
        @(negedge clk_DM);
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk_DM); #1;
        check("bp.release_valid1", 32'(rsp_valid1), 32'd0);
        check("bp.release_valid2", 32'(rsp_valid2), 32'd0);
        run_vec("bp.reload", '{1'b0, 8'h10, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0});

        // Reset during ACCESS of a store drops it
        run_vec("rst.pre", '{1'b1, 8'h30, 2'b10, 1'b0, 32'hAAAA5555, 32'h0, 1'b0});
        @(negedge clk_DM);
        req_we = 1'b1; req_addr = 8'h30; req_siz = 2'b10; req_wdata = 32'h12345678;
        req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk_DM); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst.rsp_valid1", 32'(rsp_valid1), 32'd0);
        check("rst.rsp_valid2", 32'(rsp_valid2), 32'd0);
        check("rst.req_ready1", 32'(req_ready1), 32'd1);
        check("rst.req_ready2", 32'(req_ready2), 32'd1);
        @(negedge clk_DM);
        rst_n = 1'b1;
        @(posedge clk_DM); #1;
        check("rst.after_ready1", 32'(req_ready1), 32'd1);
        check("rst.after_valid1", 32'(rsp_valid1), 32'd0);
        run_vec("rst.reload", '{1'b0, 8'h30, 2'b10, 1'b0, 32'h0, 32'hAAAA5555, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dm_access_unit.md
# dm_access_unit

Parametrised data-memory access unit for the CPU: a word-organised synchronous RAM behind a valid/ready request/response handshake, supporting byte, halfword and word loads and stores with little-endian lane placement and optional sign extension. It replaces the fixed 64-word, handshake-free data RAM. It adds configurable depth, configurable read latency, back-to-back throughput and an error response for illegal accesses. It sits between the execute/memory stage and the load writeback path.

## Interface
- ADDR_W, 8, byte-address width; array depth = 2**(ADDR_W-2) 32-bit words (legal range 4..16)
- RD_LAT, 1, array read pipeline depth in cycles (legal values 1 or 2)
- clk_DM  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_siz  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_se  in  1  sign-extend load result (byte/half only)
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  32  load result; 0 for stores and errored accesses
- rsp_err  out  1  access was illegal (see Configuration)

## Operation
- FSM states: IDLE, ACCESS, WAIT (only when RD_LAT=2), RESP.
- req_ready = (state==IDLE) | (state==RESP & rsp_ready).
- On handshake (req_valid & req_ready), latch we/addr/siz/se/wdata and go to ACCESS.
- ACCESS: present word address addr[ADDR_W-1:2] to the array. Stores write the enabled byte lanes at the end of the cycle. Loads register the addressed word at the end of the cycle. Next state is WAIT if RD_LAT=2, else RESP.
- WAIT: second read register stage, then RESP.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready. On rsp_ready with a new request accepted, go to ACCESS; on rsp_ready alone, go to IDLE.
- Byte lanes: byte k of the word occupies bits [8k+7:8k].
- Byte store: enable lane addr[1:0], data replicated x4.
- Half store: enable lanes {addr[1],0} and {addr[1],1}, data replicated x2.
- Word store: enable all four lanes.
- Load extract: shift right by addr[1:0]*8 (byte) or addr[1]*16 (half). Zero-extend, or sign-extend when req_se=1. Word loads ignore req_se.
- Load rdata depends only on the latched request and the registered word, not on live inputs.
- A store followed immediately by a load to the same word returns the new data. No bypass is needed, since the write completes before the next read edge.
- Array contents are not reset and are undefined until written.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, all latched request fields 0. req_ready reads 1 after reset.
- Latency, handshake edge to rsp_valid high: 1+RD_LAT edges (2 for RD_LAT=1, 3 for RD_LAT=2). Stores and errors have the same latency.
- Throughput with rsp_ready held high: one access per 1+RD_LAT cycles.
- Backpressure: with rsp_ready low, RESP persists indefinitely and no request is accepted.
- Reset asserted mid-access returns to IDLE immediately and drops the response. A store is lost unless its ACCESS edge has already occurred.
- req_valid without req_ready: the request must be held by the sender. The unit samples nothing.

## Configuration
- DM_ALIGN_CHECK_EN defined:
  - siz=11, half with addr[0]=1, and word with addr[1:0]!=0 are illegal.
  - Illegal accesses perform no array write and return rsp_err=1, rsp_rdata=0, with normal latency.
- DM_ALIGN_CHECK_EN undefined:
  - Legacy behaviour: siz=11 acts as a word access.
  - Offending low address bits are ignored (half uses addr[1] only; word ignores addr[1:0]).
  - rsp_err is tied 0.

## Structure
- Package dm_pkg holds:
  - size encodings SIZ_B, SIZ_H, SIZ_W, SIZ_RSV
  - FSM state enum
  - function computing the 4-bit lane-enable from siz/addr
- Sub-module dm_lane_unit is purely combinational. It produces write-data replication and the lane-enable mask, plus load extract and sign extension.
- Top holds the FSM, request latch, inferred array and read pipeline registers.

## Test plan
- Word store 0xDEADBEEF @0x10, then byte load se=1 @0x13 -> 0xFFFFFFDE; se=0 @0x11 -> 0x000000BE.
- Half store 0x8001 @0x22, then word load @0x20 -> bytes 0x22–0x23 = 0x8001; half load se=1 @0x22 -> 0xFFFF8001.
- RD_LAT=1 and RD_LAT=2 builds: rsp_valid rises exactly 2 and 3 edges after handshake; back-to-back loads with rsp_ready=1 achieve one per 2 and 3 cycles respectively.
- rsp_ready held low for 5 cycles: rsp_rdata and rsp_valid stable, req_ready=0, new req_valid not accepted.
- With DM_ALIGN_CHECK_EN: word store @0x05 -> rsp_err=1, and a subsequent word load @0x04 shows memory unchanged. Without the macro: the same store writes word 0x04.
- rst_n pulsed low during ACCESS of store 0x12345678 @0x30 -> rsp_valid 0, state IDLE, req_ready 1 after release.
